// File: rtl/shiftreg_drain_fifo.sv
// Synchronous FIFO buffering bytes drained from the shift chain tail.
// Registered level/full/empty; head byte reads as zero while empty.
module shiftreg_drain_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Flush wins over any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/shiftreg_drain.sv
// Consumer end of the byte-wide shift chain: owns shift enable, counts priming
// shifts, then buffers each byte leaving the chain tail into an output FIFO.
module shiftreg_drain #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHAIN_LEN  = 900,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              sr_data,
  output logic                          shift_en,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          primed,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);

  logic [CntW-1:0] prime_cnt_q, prime_cnt_d;
  logic            primed_q, primed_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  // full is registered inside the FIFO, so out_ready never reaches shift_en.
  assign shift_en  = enable & ~fifo_full & ~flush & ~rst;
  assign push      = shift_en & primed_q;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign primed    = primed_q;

  always_comb begin
    prime_cnt_d = prime_cnt_q;
    if (flush) begin
      prime_cnt_d = '0;
    end else if (shift_en && (prime_cnt_q != CntW'(CHAIN_LEN))) begin
      prime_cnt_d = prime_cnt_q + CntW'(1);
    end
    primed_d = (prime_cnt_d == CntW'(CHAIN_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
    end
  end

  shiftreg_drain_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (sr_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_shiftreg_drain.sv
// Directed bench for shiftreg_drain with a 4-stage chain model fed 0x01,0x02,...
module tb_shiftreg_drain;

  localparam int unsigned W  = 8;
  localparam int unsigned CL = 4;
  localparam int unsigned FD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         model_rst = 1'b1;
  logic         enable = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] sr_data;
  logic         shift_en;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         primed;
  logic [2:0]   level;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] c0, c1, c2, c3, feed;

  always #5 clk = ~clk;

  // Chain model: shifts only on shift_en, never cleared by flush or DUT reset.
  always @(posedge clk) begin
    if (model_rst) begin
      c0 <= '0; c1 <= '0; c2 <= '0; c3 <= '0; feed <= 8'h01;
    end else if (shift_en) begin
      c0 <= feed; c1 <= c0; c2 <= c1; c3 <= c2; feed <= feed + 8'h01;
    end
  end
  assign sr_data = c3;

  shiftreg_drain #(
    .WIDTH      (W),
    .CHAIN_LEN  (CL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .flush     (flush),
    .sr_data   (sr_data),
    .shift_en  (shift_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .primed    (primed),
    .level     (level)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; model_rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; model_rst = 1'b0;
  endtask

  task automatic prime();
    enable = 1'b1;
    repeat (CL) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, primed, level, out_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: valid=%b primed=%b level=%0d data=%h, want all 0",
               out_valid, primed, level, out_data);
    end
    rst = 1'b1; enable = 1'b1;
    #1;
    checks++;
    if (shift_en !== 1'b0) begin
      errors++;
      $display("FAIL shift_en_in_rst: got %b want 0", shift_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (shift_en !== 1'b1) begin
      errors++;
      $display("FAIL shift_en_after_rst: got %b want 1", shift_en);
    end
    enable = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (primed !== (k == 4)) begin
        errors++;
        $display("FAIL prime_shift%0d: primed=%b want %b", k, primed, (k == 4));
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL primed_no_output: valid=%b want 0", out_valid);
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || level !== 3'd1) begin
        errors++;
        $display("FAIL stream_byte%0d: valid=%b data=%h level=%0d want 1 %h 1",
                 i, out_valid, out_data, level, W'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    prime();
    repeat (4) @(negedge clk);
    checks++;
    if (level !== 3'd4 || shift_en !== 1'b0 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL bp_full: level=%0d shift_en=%b data=%h want 4 0 01",
               level, shift_en, out_data);
    end
    @(negedge clk);
    checks++;
    if (level !== 3'd4 || shift_en !== 1'b0 || out_data !== 8'h01 || sr_data !== 8'h05) begin
      errors++;
      $display("FAIL bp_hold: level=%0d shift_en=%b data=%h tail=%h want 4 0 01 05",
               level, shift_en, out_data, sr_data);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, W'(i));
      end
      if (i == 2) begin
        checks++;
        if (level !== 3'd3 || shift_en !== 1'b1) begin
          errors++;
          $display("FAIL bp_resume: level=%0d shift_en=%b want 3 1", level, shift_en);
        end
      end
    end
  endtask

  task automatic test_toggle_ready();
    logic [W-1:0] got [$];
    do_reset();
    prime();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = ~out_ready;
      if (out_valid && out_ready) got.push_back(out_data);
    end
    out_ready = 1'b0;
    checks++;
    if (got.size() < 18) begin
      errors++;
      $display("FAIL toggle_count: got %0d bytes want >= 18", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(i + 1)) begin
        errors++;
        $display("FAIL toggle_order%0d: got %h want %h", i, got[i], W'(i + 1));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    prime();
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre_level: got %0d want 3", level);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (shift_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_shift_en: got %b want 0", shift_en);
    end
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b primed=%b level=%0d want 0 0 0",
               out_valid, primed, level);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (primed !== 1'b0) begin
      errors++;
      $display("FAIL flush_reprime3: primed=%b want 0", primed);
    end
    @(negedge clk);
    checks++;
    if (primed !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_reprime4: primed=%b valid=%b want 1 0", primed, out_valid);
    end
    for (int i = 8; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++;
        $display("FAIL flush_first%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, W'(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    prime();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (shift_en !== 1'b0 || level !== 3'd2) begin
      errors++;
      $display("FAIL midrst_during: shift_en=%b level=%0d want 0 2", shift_en, level);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, primed, level, out_data} !== 12'h000 || shift_en !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: valid=%b primed=%b level=%0d data=%h shift_en=%b want 0 0 0 00 1",
               out_valid, primed, level, out_data, shift_en);
    end
  endtask

  task automatic test_enable_low();
    do_reset();
    prime();
    repeat (2) @(negedge clk);
    checks++;
    if (level !== 3'd2 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL en_pre: level=%0d data=%h want 2 01", level, out_data);
    end
    enable = 1'b0;
    out_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (shift_en !== 1'b0 || primed !== 1'b1) begin
        errors++;
        $display("FAIL en_hold%0d: shift_en=%b primed=%b want 0 1", c, shift_en, primed);
      end
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || level !== 3'd1) begin
          errors++;
          $display("FAIL en_drain1: valid=%b data=%h level=%0d want 1 02 1",
                   out_valid, out_data, level);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL en_drained: valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle_ready();
    test_flush();
    test_mid_reset();
    test_enable_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
